// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the memory requester.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned TO_CNT_W   = 8;

    typedef enum logic {
        StIdle    = 1'b0,
        StWaitAck = 1'b1
    } state_t;

endpackage

// File: rtl/req_fifo.sv
// Request queue: power-of-two depth circular buffer with full/empty/count.
module req_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // Storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_requester.sv
// Queues client requests and issues them one at a time to a memory controller slot,
// with ack/timeout handling and a single-cycle response pulse.
module mem_requester
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_we,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_we,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_do,
    output logic              busy
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W + 1;
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    logic [ENTRY_W-1:0] head;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [FCNT_W-1:0]  fifo_count;

    state_t              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_di_q, mem_di_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid),
        .wdata ({req_we, req_addr, req_wdata}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign req_ready = !fifo_full;
    assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
    assign busy      = !fifo_empty || (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_addr_d  = mem_addr_q;
        mem_di_d    = mem_di_q;
        mem_we_d    = mem_we_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = head[ENTRY_W-1];
                    mem_addr_d = head[DATA_W +: ADDR_W];
                    mem_di_d   = head[DATA_W-1:0];
                    cnt_d      = '0;
                    state_d    = StWaitAck;
                end
            end
            StWaitAck: begin
                // Ack wins over a timeout landing on the same edge.
                if (mem_ack) begin
                    mem_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = mem_we_q;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = mem_we_q ? '0 : mem_do;
                    state_d     = StIdle;
                end else if (cnt_q == TO_LAST) begin
                    mem_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = mem_we_q;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    cnt_d       = cnt_q + 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_di_q    <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_di_q    <= mem_di_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_di    = mem_di_q;
    assign mem_we    = mem_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester at default parameters (depth 4, timeout 15).
module tb_mem_requester;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_we, rsp_err;
    logic [7:0] rsp_rdata;
    logic       mem_en, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_di, mem_do;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mem_requester dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_we    (rsp_we),
        .rsp_err   (rsp_err),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_di    (mem_di),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .mem_do    (mem_do),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ack   = 1'b0;
        mem_do    = 8'hEE;
        #1;
        chk("reset_mem_en", mem_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_mem_addr", mem_addr, 0);
        step();
        step();
        reset = 1'b0;

        // Read: addr 5, ack sampled on the third WAIT_ACK edge.
        req_valid = 1'b1; req_addr = 8'd5; req_we = 1'b0;
        step();
        req_valid = 1'b0;
        chk("rd_en_after_push", mem_en, 0);
        chk("rd_busy", busy, 1);
        step();
        chk("rd_en_issue", mem_en, 1);
        chk("rd_addr", mem_addr, 8'd5);
        chk("rd_we", mem_we, 0);
        step();
        chk("rd_en_c2", mem_en, 1);
        step();
        chk("rd_en_c3", mem_en, 1);
        mem_ack = 1'b1; mem_do = 8'd17;
        step();
        mem_ack = 1'b0; mem_do = 8'd99;
        chk("rd_en_drop", mem_en, 0);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rdata", rsp_rdata, 8'd17);
        chk("rd_rsp_we", rsp_we, 0);
        chk("rd_rsp_err", rsp_err, 0);
        step();
        chk("rd_rsp_pulse", rsp_valid, 0);
        chk("rd_idle_busy", busy, 0);

        // Write: addr 0x0A data 42, ack after one cycle; mem_do must be ignored.
        req_valid = 1'b1; req_addr = 8'h0A; req_wdata = 8'd42; req_we = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("wr_en", mem_en, 1);
        chk("wr_di", mem_di, 8'd42);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 8'h0A);
        mem_ack = 1'b1; mem_do = 8'd55;
        step();
        mem_ack = 1'b0;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rdata", rsp_rdata, 0);
        chk("wr_rsp_we", rsp_we, 1);
        chk("wr_en_drop", mem_en, 0);
        step();

        // Queue: 5 back-to-back reads; first goes in flight, four fill the FIFO.
        req_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 8'h20 + 8'(i);
            step();
        end
        req_valid = 1'b0;
        chk("q_full_ready", req_ready, 0);
        chk("q_inflight_addr", mem_addr, 8'h20);
        mem_ack = 1'b1; mem_do = 8'h60;
        step();
        chk("q_rsp0_valid", rsp_valid, 1);
        chk("q_rsp0_rdata", rsp_rdata, 8'h60);
        chk("q_rsp0_en_low", mem_en, 0);
        chk("q_still_full", req_ready, 0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("q_issue_en", mem_en, 1);
            chk("q_issue_addr", mem_addr, 8'h20 + 8'(i));
            chk("q_issue_no_rsp", rsp_valid, 0);
            chk("q_ready_after_pop", req_ready, 1);
            mem_do = 8'h60 + 8'(i);
            step();
            chk("q_rsp_valid", rsp_valid, 1);
            chk("q_rsp_rdata", rsp_rdata, 8'h60 + 8'(i));
            chk("q_gap_en_low", mem_en, 0);
        end
        mem_ack = 1'b0;
        step();
        chk("q_done_busy", busy, 0);

        // Timeout: read never acked; mem_en must stay high exactly 15 cycles.
        req_valid = 1'b1; req_addr = 8'h33;
        step();
        req_valid = 1'b0;
        step();
        chk("to_en_issue", mem_en, 1);
        bad = 0;
        for (int k = 1; k < 15; k++) begin
            step();
            if (mem_en !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        chk("to_held_cycles", bad, 0);
        mem_do = 8'hAB;
        step();
        chk("to_en_drop", mem_en, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("to_stray_ack", rsp_valid, 0);
        step();
        chk("to_stray_ack2", rsp_valid, 0);
        chk("to_idle_busy", busy, 0);

        // Ack on the 15th cycle beats the timeout.
        req_valid = 1'b1; req_addr = 8'h34;
        step();
        req_valid = 1'b0;
        step();
        for (int k = 1; k < 15; k++) step();
        chk("at_en_before", mem_en, 1);
        mem_ack = 1'b1; mem_do = 8'h77;
        step();
        mem_ack = 1'b0;
        chk("at_rsp_valid", rsp_valid, 1);
        chk("at_rsp_err", rsp_err, 0);
        chk("at_rdata", rsp_rdata, 8'h77);
        step();

        // Reset mid-WAIT_ACK with two requests queued.
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 8'h50 + 8'(i);
            step();
        end
        req_valid = 1'b0;
        chk("rst_pre_en", mem_en, 1);
        chk("rst_pre_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_en", mem_en, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_ready", req_ready, 1);
        chk("rst_async_addr", mem_addr, 0);
        step();
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rsp_valid !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("rst_no_residual", bad, 0);
        req_valid = 1'b1; req_addr = 8'h44;
        step();
        req_valid = 1'b0;
        step();
        chk("post_rst_en", mem_en, 1);
        chk("post_rst_addr", mem_addr, 8'h44);
        mem_ack = 1'b1; mem_do = 8'h55;
        step();
        mem_ack = 1'b0;
        chk("post_rst_rsp", rsp_valid, 1);
        chk("post_rst_rdata", rsp_rdata, 8'h55);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
